// File: rtl/alu_cmd_master.sv
// Command front end for the combinational 8/32-bit ALU: registers one
// operation, samples the ALU result a cycle later and returns it.
// Ports: cmd_* (valid/ready command in), alu_* (registered operands out,
// alu_ans result in), rsp_* (valid/ready response out), op_count.
module alu_cmd_master #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_num1,
  input  logic [31:0]      cmd_num2,
  input  logic [2:0]       cmd_op,
  output logic [7:0]       alu_num1,
  output logic [31:0]      alu_num2,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_ans,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       num1_q, num1_d;
  logic [31:0]      num2_q, num2_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == S_IDLE: if (accept) state_d = S_EXEC;
      state_q == S_EXEC: state_d = S_RESP;
      state_q == S_RESP: if (done) state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // cmd_ready only looks at state and reset, never at cmd_* or rsp_ready.
  always_comb begin
    cmd_ready = rst_n && (state_q == S_IDLE);
    accept    = cmd_valid && cmd_ready;
    done      = valid_q && rsp_ready;
  end

  always_comb begin
    num1_d  = num1_q;
    num2_d  = num2_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      num1_d = cmd_num1;
      num2_d = cmd_num2;
      op_d   = cmd_op;
    end
    // One cycle after registration the ALU output has settled.
    if (state_q == S_EXEC) begin
      data_d  = alu_ans;
      err_d   = op_q[2] & op_q[1];
      valid_d = 1'b1;
    end
    if (done) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign alu_num1  = num1_q;
  assign alu_num2  = num2_q;
  assign alu_op    = op_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign op_count  = cnt_q;

endmodule
